// File: rtl/alu_core_if.sv
// alu_core_if: operation request and result bus between control_unit and alu_core.
//
// Handshake: alu_func != 0 is the request and must be held by the master until
// alu_end is seen. alu_end is a one-cycle completion pulse. The request is retired
// by returning alu_func to 0, which frees the ALU to accept the next operation.
// alu_out, zf and cf stay valid from the alu_end cycle until the next completion.
interface alu_core_if #(
   parameter int WIDTH = 16
);
   logic [3:0]       alu_func;
   logic             alu_in_sel;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [7:0]       imm;
   logic [WIDTH-1:0] alu_out;
   logic             alu_end;
   logic             zf;
   logic             cf;

   // Control side: issues operations, consumes results
   modport master (
      output alu_func, alu_in_sel, reg_a, reg_b, imm,
      input  alu_out, alu_end, zf, cf
   );

   // ALU side: consumes operations, produces results
   modport slave (
      input  alu_func, alu_in_sel, reg_a, reg_b, imm,
      output alu_out, alu_end, zf, cf
   );
endinterface

// File: rtl/alu_core.sv
// alu_core: sequential 16-bit ALU downstream of control_unit.
// Single-cycle ops finish on the launch edge; MUL is a 16-step shift-add.
// Optional feature macro: ALU_MUL_EN (builds the iterative multiplier; without it
// code 9 behaves like a reserved code).
// dbg_state exposes the FSM state: 0 = IDLE, 1 = MUL, 2 = HOLD.
module alu_core #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   alu_core_if.slave  bus,
   output logic [1:0] dbg_state
);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_NOT = 4'h6;
   localparam logic [3:0] OP_SHL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'h9;
`endif
   localparam logic [3:0] OP_MOV = 4'hA;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] b_sel;
   logic [3:0]       sh;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   shl_w;
   logic [WIDTH:0]   shr_w;
   logic [WIDTH-1:0] res_single;
   logic             cf_single;

   logic             is_mul;
   logic             mul_last;
   logic [WIDTH-1:0] mul_res;
   logic             mul_cf;

   logic             single_done;
   logic             mul_done;
   logic             done;
   logic [WIDTH-1:0] res_next;
   logic             cf_next;

   assign dbg_state = state;

   // Single-cycle result and carry from the live operands (used on the launch edge)
   always_comb begin
      b_sel = bus.alu_in_sel ? {{(WIDTH-8){1'b0}}, bus.imm} : bus.reg_b;
      sh    = b_sel[3:0];
      sum_w = {1'b0, bus.reg_a} + {1'b0, b_sel};
      // Extra bit above/below the operand catches the last bit shifted out;
      // a shift of 0 leaves it at 0, which gives cf = 0 for free.
      shl_w = {1'b0, bus.reg_a} << sh;
      shr_w = {bus.reg_a, 1'b0} >> sh;
      res_single = '0;
      cf_single  = 1'b0;
      case (bus.alu_func)
         OP_ADD: begin
            res_single = sum_w[WIDTH-1:0];
            cf_single  = sum_w[WIDTH];
         end
         OP_SUB: begin
            res_single = bus.reg_a - b_sel;
            cf_single  = (bus.reg_a < b_sel);
         end
         OP_AND: res_single = bus.reg_a & b_sel;
         OP_OR:  res_single = bus.reg_a | b_sel;
         OP_XOR: res_single = bus.reg_a ^ b_sel;
         OP_NOT: res_single = ~bus.reg_a;
         OP_SHL: begin
            res_single = shl_w[WIDTH-1:0];
            cf_single  = shl_w[WIDTH];
         end
         OP_SHR: begin
            res_single = shr_w[WIDTH:1];
            cf_single  = shr_w[0];
         end
         OP_MOV: res_single = b_sel;
         default: begin
            res_single = '0;
            cf_single  = 1'b0;
         end
      endcase
   end

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   mplier;
   logic [3:0]         cnt;

   // One shift-add step; the final step's sum is the full product
   always_comb begin
      is_mul   = (bus.alu_func == OP_MUL);
      acc_step = mplier[0] ? (acc + mcand) : acc;
      mul_last = (cnt == 4'd15);
      mul_res  = acc_step[WIDTH-1:0];
      mul_cf   = |acc_step[2*WIDTH-1:WIDTH];
   end

   // Multiplier registers: operands captured at launch, then shifted each step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (state == S_IDLE && is_mul) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, bus.reg_a};
         mplier <= b_sel;
         cnt    <= '0;
      end else if (state == S_MUL) begin
         acc    <= acc_step;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 4'd1;
      end
   end
`else
   // Multiplier not built: code 9 falls through to the reserved path
   always_comb begin
      is_mul   = 1'b0;
      mul_last = 1'b0;
      mul_res  = '0;
      mul_cf   = 1'b0;
   end
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   // FSM next state; HOLD waits for the opcode to drop so a held code cannot retrigger
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (bus.alu_func != OP_NOP) state_n = is_mul ? S_MUL : S_HOLD;
         S_MUL:  if (mul_last) state_n = S_HOLD;
         S_HOLD: if (bus.alu_func == OP_NOP) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // FSM outputs: which edge completes an op, and the value it commits
   always_comb begin
      single_done = (state == S_IDLE) && (bus.alu_func != OP_NOP) && !is_mul;
      mul_done    = (state == S_MUL) && mul_last;
      done        = single_done | mul_done;
      res_next    = mul_done ? mul_res : res_single;
      cf_next     = mul_done ? mul_cf  : cf_single;
   end

   // Result and flag registers; only a completing edge updates them
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.alu_out <= '0;
         bus.alu_end <= 1'b0;
         bus.zf      <= 1'b0;
         bus.cf      <= 1'b0;
      end else begin
         bus.alu_end <= done;
         if (done) begin
            bus.alu_out <= res_next;
            bus.zf      <= (res_next == '0);
            bus.cf      <= cf_next;
         end
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed table-driven bench for alu_core, plus hand-written
// sequences for reset, held opcode, MUL latency/operand isolation and reset mid-op.
// Respects ALU_MUL_EN the same way the design does.
module tb_alu_core;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  alu_core_if #(.WIDTH(16)) bus ();

  alu_core #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  func;
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  imm;
    logic [15:0] out;
    logic        zf;
    logic        cf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] func, input logic sel,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] imm,
                         input logic [15:0] out, input logic zf, input logic cf);
    vec_t v;
    v.name = name; v.func = func; v.sel = sel; v.a = a; v.b = b; v.imm = imm;
    v.out = out; v.zf = zf; v.cf = cf;
    vecs.push_back(v);
  endtask

  // driver: expects to be called #1 after a rising edge with the DUT idle
  task automatic apply_op(input vec_t v);
    logic [15:0] e;
    bus.alu_func   = v.func;
    bus.alu_in_sel = v.sel;
    bus.reg_a      = v.a;
    bus.reg_b      = v.b;
    bus.imm        = v.imm;
    exp_q.push_back(v.out);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check({v.name, "_end"}, 32'(bus.alu_end), 32'd1);
    check({v.name, "_out"}, 32'(bus.alu_out), 32'(e));
    check({v.name, "_zf"},  32'(bus.zf), 32'(v.zf));
    check({v.name, "_cf"},  32'(bus.cf), 32'(v.cf));
    bus.alu_func = 4'h0;
    @(posedge clk); #1;
    check({v.name, "_end_clr"}, 32'(bus.alu_end), 32'd0);
    check({v.name, "_hold"},    32'(bus.alu_out), 32'(e));
    check({v.name, "_idle"},    32'(dbg_state), 32'd0);
  endtask

  initial begin : main
    int   pulses;
    int   n;
    bit   seen;
    vec_t v;

    add_vec("add_carry", 4'h1, 1'b0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 1'b1, 1'b1);
    add_vec("add_plain", 4'h1, 1'b0, 16'h1234, 16'h1111, 8'h00, 16'h2345, 1'b0, 1'b0);
    add_vec("sub_imm",   4'h2, 1'b1, 16'h0005, 16'hAAAA, 8'h07, 16'hFFFE, 1'b0, 1'b1);
    add_vec("sub_zero",  4'h2, 1'b0, 16'h0007, 16'h0007, 8'h00, 16'h0000, 1'b1, 1'b0);
    add_vec("and",       4'h3, 1'b0, 16'hF0F0, 16'h3C3C, 8'h00, 16'h3030, 1'b0, 1'b0);
    add_vec("or",        4'h4, 1'b0, 16'hF0F0, 16'h0F00, 8'h00, 16'hFFF0, 1'b0, 1'b0);
    add_vec("xor",       4'h5, 1'b0, 16'hAAAA, 16'hFFFF, 8'h00, 16'h5555, 1'b0, 1'b0);
    add_vec("not",       4'h6, 1'b0, 16'h00FF, 16'h1234, 8'h00, 16'hFF00, 1'b0, 1'b0);
    add_vec("shl1",      4'h7, 1'b0, 16'h8001, 16'h0001, 8'h00, 16'h0002, 1'b0, 1'b1);
    add_vec("shl0",      4'h7, 1'b0, 16'h0001, 16'h0010, 8'h00, 16'h0001, 1'b0, 1'b0);
    add_vec("shl2_out",  4'h7, 1'b0, 16'h4000, 16'h0002, 8'h00, 16'h0000, 1'b1, 1'b1);
    add_vec("shr1",      4'h8, 1'b0, 16'h0003, 16'h0001, 8'h00, 16'h0001, 1'b0, 1'b1);
    add_vec("shr15",     4'h8, 1'b0, 16'h8000, 16'h000F, 8'h00, 16'h0001, 1'b0, 1'b0);
    add_vec("mov_imm",   4'hA, 1'b1, 16'h1111, 16'h2222, 8'h80, 16'h0080, 1'b0, 1'b0);
    add_vec("mov_zero",  4'hA, 1'b0, 16'h1111, 16'h0000, 8'h55, 16'h0000, 1'b1, 1'b0);
    add_vec("rsvd_b",    4'hB, 1'b0, 16'h0001, 16'h0001, 8'h00, 16'h0000, 1'b1, 1'b0);
    add_vec("rsvd_f",    4'hF, 1'b0, 16'hFFFF, 16'hFFFF, 8'h00, 16'h0000, 1'b1, 1'b0);
`ifndef ALU_MUL_EN
    add_vec("mul_off",   4'h9, 1'b0, 16'h0123, 16'h0456, 8'h00, 16'h0000, 1'b1, 1'b0);
`endif

    // reset asserted with a nonzero opcode present
    rst = 1'b0;
    bus.alu_func = 4'h1; bus.alu_in_sel = 1'b0;
    bus.reg_a = 16'hFFFF; bus.reg_b = 16'h0001; bus.imm = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",   32'(bus.alu_out), 32'h0);
    check("rst_end",   32'(bus.alu_end), 32'd0);
    check("rst_zf",    32'(bus.zf), 32'd0);
    check("rst_cf",    32'(bus.cf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    bus.alu_func = 4'h0;
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.alu_end) pulses++;
    end
    check("idle_no_pulse", 32'(pulses), 32'd0);
    check("idle_state",    32'(dbg_state), 32'd0);
    check("idle_out",      32'(bus.alu_out), 32'h0);

    // table-driven single-cycle ops
    for (int i = 0; i < vecs.size(); i++) apply_op(vecs[i]);

    // held opcode: SUB with immediate held for 5 cycles gives exactly one pulse
    bus.alu_func = 4'h2; bus.alu_in_sel = 1'b1;
    bus.reg_a = 16'h0005; bus.imm = 8'h07;
    @(posedge clk); #1;
    check("held_end", 32'(bus.alu_end), 32'd1);
    check("held_out", 32'(bus.alu_out), 32'hFFFE);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.alu_end) pulses++;
    end
    check("held_no_repulse", 32'(pulses), 32'd0);
    check("held_state",      32'(dbg_state), 32'd2);
    bus.alu_func = 4'h0;
    @(posedge clk); #1;
    check("held_release", 32'(dbg_state), 32'd0);

`ifdef ALU_MUL_EN
    // MUL: 0x0123 * 0x0456 = 0x4EDC2 -> low half 0xEDC2, upper half nonzero
    bus.alu_func = 4'h9; bus.alu_in_sel = 1'b0;
    bus.reg_a = 16'h0123; bus.reg_b = 16'h0456;
    @(posedge clk); #1;
    bus.alu_func = 4'h0;
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (i == 3) check("mul_state", 32'(dbg_state), 32'd1);
      if (i == 5) begin
        bus.reg_a = 16'hFFFF; bus.reg_b = 16'hFFFF;
        bus.alu_in_sel = 1'b1; bus.imm = 8'hFF;
      end
      if (bus.alu_end) begin seen = 1'b1; n = i; end
    end
    check("mul_latency", 32'(n), 32'd16);
    check("mul_out", 32'(bus.alu_out), 32'hEDC2);
    check("mul_cf",  32'(bus.cf), 32'd1);
    check("mul_zf",  32'(bus.zf), 32'd0);
    @(posedge clk); #1;
    check("mul_end_clr", 32'(bus.alu_end), 32'd0);
    check("mul_idle",    32'(dbg_state), 32'd0);

    // reset mid-MUL: launch, run 8 steps, then pulse reset asynchronously
    bus.alu_func = 4'h9; bus.alu_in_sel = 1'b0;
    bus.reg_a = 16'h0003; bus.reg_b = 16'h0005;
    @(posedge clk); #1;
    bus.alu_func = 4'h0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
`else
    // no multiplier: pulse reset asynchronously after an op left nonzero outputs
    v.name = "pre_rst"; v.func = 4'h7; v.sel = 1'b0; v.a = 16'h8001; v.b = 16'h0001;
    v.imm = 8'h00; v.out = 16'h0002; v.zf = 1'b0; v.cf = 1'b1;
    apply_op(v);
    #3;
    rst = 1'b0;
    #1;
`endif
    check("arst_out",   32'(bus.alu_out), 32'h0);
    check("arst_end",   32'(bus.alu_end), 32'd0);
    check("arst_cf",    32'(bus.cf), 32'd0);
    check("arst_zf",    32'(bus.zf), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.alu_end) pulses++;
    end
    check("arst_no_end", 32'(pulses), 32'd0);

    v.name = "post_rst_add"; v.func = 4'h1; v.sel = 1'b0; v.a = 16'h0001; v.b = 16'h0002;
    v.imm = 8'h00; v.out = 16'h0003; v.zf = 1'b0; v.cf = 1'b0;
    apply_op(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
